// File: rtl/nes_pad_controller.sv
// nes_pad_controller
//   Bridges a USB HID gamepad to an NES controller port. HID reports are
//   captured and decoded to the eight NES buttons, with turbo autofire on A/B.
//   A watchdog releases every button when reports stop arriving. The console
//   reads the button snapshot over the 4021-style latch/clock/data interface.
//
// Ports
//   clk             block clock (USB host clock)
//   nreset          synchronous active-low reset
//   hid_report      latest 64-bit HID report
//   hid_report_set  one-cycle strobe, hid_report valid this cycle
//   nes_latch       console latch, asynchronous to clk
//   nes_clk         console shift clock, asynchronous to clk
//   nes_data        serial data to the console, 0 = pressed
//   pad_state       {R,L,D,U,Start,Select,B,A}, 1 = pressed
//   pad_valid       a report has arrived and the pad is not stale
//   stale           watchdog expired, or no report since reset
module nes_pad_controller #(
  parameter int STALE_CYCLES = 600000,
  parameter int TURBO_HALF   = 200000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [63:0] hid_report,
  input  logic        hid_report_set,
  input  logic        nes_latch,
  input  logic        nes_clk,
  output logic        nes_data,
  output logic [7:0]  pad_state,
  output logic        pad_valid,
  output logic        stale
);

  localparam int WD_W = $clog2(STALE_CYCLES + 1);
  localparam int TB_W = $clog2(TURBO_HALF + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALE_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_PRE = WD_W'(STALE_CYCLES - 2);
  localparam logic [TB_W-1:0] TB_MAX = TB_W'(TURBO_HALF - 1);

  logic [63:0]     report;
  logic [WD_W-1:0] wd_cnt;
  logic [TB_W-1:0] turbo_cnt;
  logic            turbo_phase;
  logic [7:0]      buttons;
  logic            turbo_gate;
  logic            latch_p0, latch_p1, latch_p2;
  logic            sclk_p0, sclk_p1, sclk_p2;
  logic [7:0]      sr;
  logic            unused_report_bits;

  // Only a handful of report bits carry button information.
  assign unused_report_bits = ^{report[63:29], report[27:24], report[21:18],
                                report[13:8], report[5:0], latch_p2};

  // With turbo held, A/B only pass during the high half of the turbo phase.
  assign turbo_gate = ~report[28] | turbo_phase;

  // Axis bytes: 0x00..0x3F is the low end, 0xC0..0xFF the high end.
  assign buttons = {&report[7:6], ~|report[7:6], &report[15:14], ~|report[15:14],
                    report[23], report[22],
                    report[17] & turbo_gate, report[16] & turbo_gate};

  assign nes_data = sr[0];

  // Capture, watchdog and registered pad output
  always_ff @(posedge clk) begin
    if (!nreset) begin
      report    <= '0;
      wd_cnt    <= '0;
      stale     <= 1'b1;
      pad_valid <= 1'b0;
      pad_state <= 8'h00;
    end else begin
      if (hid_report_set) begin
        report    <= hid_report;
        wd_cnt    <= '0;
        stale     <= 1'b0;
        pad_valid <= 1'b1;
      end else begin
        if (wd_cnt != WD_MAX)
          wd_cnt <= wd_cnt + 1'b1;
        // Stale asserts on the same edge the counter lands on its limit.
        if (wd_cnt >= WD_PRE) begin
          stale     <= 1'b1;
          pad_valid <= 1'b0;
        end
      end
      pad_state <= pad_valid ? buttons : 8'h00;
    end
  end

  // Free-running turbo phase generator
  always_ff @(posedge clk) begin
    if (!nreset) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (turbo_cnt == TB_MAX) begin
      turbo_cnt   <= '0;
      turbo_phase <= ~turbo_phase;
    end else begin
      turbo_cnt <= turbo_cnt + 1'b1;
    end
  end

  // Console-side synchronisers (p0/p1 resolve metastability, p2 for edges)
  always_ff @(posedge clk) begin
    if (!nreset) begin
      latch_p0 <= 1'b0;
      latch_p1 <= 1'b0;
      latch_p2 <= 1'b0;
      sclk_p0  <= 1'b0;
      sclk_p1  <= 1'b0;
      sclk_p2  <= 1'b0;
    end else begin
      latch_p0 <= nes_latch;
      latch_p1 <= latch_p0;
      latch_p2 <= latch_p1;
      sclk_p0  <= nes_clk;
      sclk_p1  <= sclk_p0;
      sclk_p2  <= sclk_p1;
    end
  end

  // 4021-style shift register: parallel load while latched, shift on clock rise
  always_ff @(posedge clk) begin
    if (!nreset) begin
      sr <= 8'hFF;
    end else if (latch_p1) begin
      sr <= ~pad_state;
    end else if (sclk_p1 && !sclk_p2) begin
      sr <= {1'b0, sr[7:1]};
    end
  end

endmodule

// File: tb/tb_nes_pad_controller.sv
module tb_nes_pad_controller;

  localparam int STALE = 300;
  localparam int THALF = 40;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [63:0] hid_report = '0;
  logic        hid_report_set = 1'b0;
  logic        nes_latch = 1'b0;
  logic        nes_clk = 1'b0;
  logic        nes_data;
  logic [7:0]  pad_state;
  logic        pad_valid;
  logic        stale;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] pad_q[$];
  logic       bit_q[$];

  nes_pad_controller #(.STALE_CYCLES(STALE), .TURBO_HALF(THALF)) dut (
    .clk(clk), .nreset(nreset), .hid_report(hid_report),
    .hid_report_set(hid_report_set), .nes_latch(nes_latch), .nes_clk(nes_clk),
    .nes_data(nes_data), .pad_state(pad_state), .pad_valid(pad_valid),
    .stale(stale)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [63:0] r);
    return {&r[7:6], ~|r[7:6], &r[15:14], ~|r[15:14], r[23], r[22], r[17], r[16]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] r, input bit track);
    hid_report = r;
    hid_report_set = 1'b1;
    if (track) pad_q.push_back(model(r));
    tick();
    hid_report_set = 1'b0;
  endtask

  task automatic check_pad(input string tag);
    logic [7:0] e;
    if (pad_q.size() == 0) begin
      check_eq({tag, "_qempty"}, 64'(1), 64'(0));
    end else begin
      e = pad_q.pop_front();
      check_eq(tag, 64'(pad_state), 64'(e));
    end
  endtask

  task automatic check_bit(input string tag);
    logic e;
    if (bit_q.size() == 0) begin
      check_eq({tag, "_qempty"}, 64'(1), 64'(0));
    end else begin
      e = bit_q.pop_front();
      check_eq(tag, 64'(nes_data), 64'(e));
    end
  endtask

  // Latch the console snapshot; optionally pulse nes_clk while latched.
  task automatic do_latch(input logic [7:0] exp_pad, input bit clk_during);
    for (int i = 0; i < 8; i++) bit_q.push_back(~exp_pad[i]);
    for (int i = 0; i < 3; i++) bit_q.push_back(1'b0);
    nes_latch = 1'b1;
    repeat (2) tick();
    if (clk_during) begin
      nes_clk = 1'b1;
      repeat (3) tick();
      nes_clk = 1'b0;
      repeat (3) tick();
    end else begin
      repeat (6) tick();
    end
    nes_latch = 1'b0;
    repeat (3) tick();
    check_bit("bit_first");
  endtask

  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin
      nes_clk = 1'b1;
      repeat (3) tick();
      nes_clk = 1'b0;
      repeat (3) tick();
      check_bit("bit_shift");
    end
  endtask

  initial begin
    logic [63:0] r_al, r_fullrange, r_b, r_turbo, r_mid;
    int toggles[$];
    logic prev_b;
    int bad_other;

    r_al        = 64'h0000_0000_0001_8000;  // A + Left, Y centred
    r_fullrange = 64'h0000_0000_0001_FF00;  // A + Left + Down
    r_b         = 64'h0000_0000_0002_8080;  // B only, axes centred
    r_turbo     = 64'h0000_0000_1082_8080;  // turbo, Start, B
    r_mid       = 64'h0000_0000_00C0_C0C0;  // Start, Select, Down, Right

    // Reset
    nreset = 1'b0;
    repeat (2) tick();
    check_eq("rst_pad", 64'(pad_state), 64'h00);
    check_eq("rst_valid", 64'(pad_valid), 64'(0));
    check_eq("rst_stale", 64'(stale), 64'(1));
    check_eq("rst_data", 64'(nes_data), 64'(1));
    nreset = 1'b1;
    tick();
    check_eq("idle_stale", 64'(stale), 64'(1));

    // Single capture, pad_state one edge after the load
    send(r_al, 1);
    check_eq("cap_valid", 64'(pad_valid), 64'(1));
    check_eq("cap_stale", 64'(stale), 64'(0));
    tick();
    check_pad("cap_pad");
    check_eq("cap_pad_const", 64'(pad_state), 64'h41);

    // Full serial read: A,B,Sel,Start,U,D,L,R then zeros
    do_latch(8'h41, 1'b0);
    shift_bits(10);

    // Back-to-back strobes
    send(r_fullrange, 1);
    send(r_mid, 1);
    check_pad("b2b_first");
    tick();
    check_pad("b2b_second");

    // Clock edges during latch are ignored
    do_latch(model(r_mid), 1'b1);
    shift_bits(10);

    // Latch-to-first-bit latency: shift register is all zeros after a full read
    send(r_b, 1);
    tick();
    check_pad("lat_pad");
    nes_latch = 1'b1;
    repeat (2) tick();
    check_eq("lat_2cyc", 64'(nes_data), 64'(0));
    tick();
    check_eq("lat_3cyc", 64'(nes_data), 64'(1));
    repeat (3) tick();
    nes_latch = 1'b0;
    repeat (3) tick();

    // Mid-read update: rest of the read comes from the old snapshot
    send(r_al, 1);
    tick();
    check_pad("mid_pad0");
    do_latch(8'h41, 1'b0);
    shift_bits(3);
    send(r_mid, 1);
    tick();
    check_pad("mid_pad1");
    shift_bits(7);
    do_latch(model(r_mid), 1'b0);
    shift_bits(10);

    // Watchdog expiry
    send(r_al, 0);
    repeat (STALE - 2) tick();
    check_eq("wd_pre_stale", 64'(stale), 64'(0));
    check_eq("wd_pre_pad", 64'(pad_state), 64'h41);
    tick();
    check_eq("wd_stale", 64'(stale), 64'(1));
    check_eq("wd_valid", 64'(pad_valid), 64'(0));
    check_eq("wd_pad_hold", 64'(pad_state), 64'h41);
    tick();
    check_eq("wd_pad_zero", 64'(pad_state), 64'h00);
    do_latch(8'h00, 1'b0);
    shift_bits(10);

    // Strobe in the expiry cycle wins
    send(r_al, 0);
    repeat (STALE - 2) tick();
    send(r_al, 0);
    check_eq("wd_race_stale", 64'(stale), 64'(0));
    check_eq("wd_race_valid", 64'(pad_valid), 64'(1));
    tick();
    check_eq("wd_race_pad", 64'(pad_state), 64'h41);

    // Turbo: B toggles every THALF cycles, other bits steady
    send(r_turbo, 0);
    repeat (2) tick();
    prev_b = pad_state[1];
    bad_other = 0;
    for (int i = 0; i < 5 * THALF + 10; i++) begin
      if (i % 100 == 50) hid_report_set = 1'b1;
      tick();
      hid_report_set = 1'b0;
      if ((pad_state & 8'hFD) != 8'h08) bad_other++;
      if (pad_state[1] != prev_b) toggles.push_back(i);
      prev_b = pad_state[1];
    end
    check_eq("turbo_other", 64'(bad_other), 64'(0));
    if (toggles.size() < 4) begin
      check_eq("turbo_toggles", 64'(toggles.size()), 64'(4));
    end else begin
      for (int k = 1; k < 4; k++)
        check_eq("turbo_period", 64'(toggles[k] - toggles[k-1]), 64'(THALF));
    end

    // Turbo off passes B straight through
    send(r_b, 1);
    tick();
    check_pad("turbo_off");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
